// File: rtl/cdb_arbiter.sv
// Common data bus arbiter. Each result source feeds a private FIFO. A round-robin
// arbiter picks one head per cycle and drives it onto a registered broadcast bus.
module cdb_arbiter #(
    parameter int NSRC  = 4,
    parameter int DEPTH = 4,
    parameter int TAGW  = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [NSRC*TAGW-1:0] src_tag,
    input  logic [NSRC*32-1:0]   src_data,
    output logic [NSRC-1:0]      src_full,
    output logic [TAGW-1:0]      cdb_tag,
    output logic [31:0]          cdb_data,
    output logic                 overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int EW = TAGW + 32;

    logic [NSRC-1:0]         req, pop, byp, push, ovf_set;
    logic [NSRC-1:0][EW-1:0] head;
    logic                    gnt;
    logic [RW-1:0]           gidx, rr_q, rr_d;
    logic [TAGW-1:0]         cdb_tag_q;
    logic [31:0]             cdb_data_q;
    logic                    ovf_q;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        logic [DEPTH-1:0][EW-1:0] mem_q;
        logic [PW-1:0]            rd_q, wr_q;
        logic [CW-1:0]            cnt_q;
        logic                     in_vld, empty;
        logic [EW-1:0]            live;

        assign live   = {src_tag[i*TAGW +: TAGW], src_data[i*32 +: 32]};
        assign in_vld = |src_tag[i*TAGW +: TAGW];
        assign empty  = (cnt_q == '0);

        // Buffered entries always go first; the live input only bypasses an empty FIFO.
        assign req[i]      = !empty || in_vld;
        assign head[i]     = empty ? live : mem_q[rd_q];
        assign pop[i]      = gnt && (gidx == RW'(i)) && !empty;
        assign byp[i]      = gnt && (gidx == RW'(i)) && empty;
        assign push[i]     = in_vld && !byp[i] && ((cnt_q != CW'(DEPTH)) || pop[i]);
        assign ovf_set[i]  = in_vld && (cnt_q == CW'(DEPTH)) && !pop[i];
        assign src_full[i] = (cnt_q == CW'(DEPTH));

        always_ff @(posedge clk) begin
            if (reset || flush) begin
                rd_q  <= '0;
                wr_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (push[i]) begin
                    mem_q[wr_q] <= live;
                    wr_q        <= wr_q + PW'(1);
                end
                if (pop[i])
                    rd_q <= rd_q + PW'(1);
                if (push[i] && !pop[i])
                    cnt_q <= cnt_q + CW'(1);
                else if (pop[i] && !push[i])
                    cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    always_comb begin
        gnt  = 1'b0;
        gidx = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (!gnt && req[(int'(rr_q) + k) % NSRC]) begin
                gnt  = 1'b1;
                gidx = RW'((int'(rr_q) + k) % NSRC);
            end
        end
        rr_d = rr_q;
        if (gnt)
            rr_d = (int'(gidx) == NSRC - 1) ? '0 : gidx + RW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q       <= '0;
            cdb_tag_q  <= '0;
            cdb_data_q <= '0;
            ovf_q      <= 1'b0;
        end else if (flush) begin
            rr_q       <= '0;
            cdb_tag_q  <= '0;
            cdb_data_q <= '0;
        end else begin
            rr_q <= rr_d;
            {cdb_tag_q, cdb_data_q} <= gnt ? head[gidx] : '0;
            if (|ovf_set)
                ovf_q <= 1'b1;
        end
    end

    assign cdb_tag  = cdb_tag_q;
    assign cdb_data = cdb_data_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: each step drives one cycle of inputs, then the
// registered bus, full flags and overflow are compared against hand-derived values.
module tb_cdb_arbiter;
    logic        clk = 1'b0;
    logic        reset, flush;
    logic [19:0] src_tag;
    logic [127:0] src_data;
    logic [3:0]  src_full;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        overflow;
    int checks = 0;
    int fails  = 0;

    cdb_arbiter #(.NSRC(4), .DEPTH(4), .TAGW(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .src_tag(src_tag), .src_data(src_data), .src_full(src_full),
        .cdb_tag(cdb_tag), .cdb_data(cdb_data), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dat(input logic [4:0] t);
        return 32'hC0DE_0000 + 32'h0000_0111 * 32'(t);
    endfunction

    // One clock of stimulus: tags for alu, ld_str, mul, div; then sample 1 ns after the edge.
    task automatic step(input logic [4:0] a, l, m, d, input logic fl, input logic rs);
        src_tag  = {d, m, l, a};
        src_data = {dat(d), dat(m), dat(l), dat(a)};
        flush    = fl;
        reset    = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string nm, input logic [4:0] et, input logic [3:0] ef, input logic eo);
        logic [31:0] ed;
        ed = (et == 5'd0) ? 32'd0 : dat(et);
        checks++;
        assert (cdb_tag === et) else begin
            fails++; $error("FAIL %s cdb_tag got %0d exp %0d", nm, cdb_tag, et);
        end
        checks++;
        assert (cdb_data === ed) else begin
            fails++; $error("FAIL %s cdb_data got %h exp %h", nm, cdb_data, ed);
        end
        checks++;
        assert (src_full === ef) else begin
            fails++; $error("FAIL %s src_full got %b exp %b", nm, src_full, ef);
        end
        checks++;
        assert (overflow === eo) else begin
            fails++; $error("FAIL %s overflow got %b exp %b", nm, overflow, eo);
        end
    endtask

    initial begin
        src_tag = '0; src_data = '0; flush = 1'b0; reset = 1'b1;
        step(0, 0, 0, 0, 1'b0, 1'b1);
        step(0, 0, 0, 0, 1'b0, 1'b1);
        chk("reset", 0, 4'b0000, 0);

        // single alu result: one bus cycle, then idle
        step(3, 0, 0, 0, 1'b0, 1'b0); chk("single_c1", 3, 4'b0000, 0);
        idle();                       chk("single_c2", 0, 4'b0000, 0);

        // all four at once from rr=0, then rr wraps back to 0 after div
        step(0, 0, 0, 0, 1'b0, 1'b1); chk("reset2", 0, 4'b0000, 0);
        step(1, 2, 3, 4, 1'b0, 1'b0); chk("all4_c1", 1, 4'b0000, 0);
        idle(); chk("all4_c2", 2, 4'b0000, 0);
        idle(); chk("all4_c3", 3, 4'b0000, 0);
        idle(); chk("all4_c4", 4, 4'b0000, 0);
        idle(); chk("all4_c5", 0, 4'b0000, 0);
        step(5, 6, 0, 0, 1'b0, 1'b0); chk("rr_wrap_a", 5, 4'b0000, 0);
        idle(); chk("rr_wrap_b", 6, 4'b0000, 0);
        idle(); chk("rr_wrap_c", 0, 4'b0000, 0);

        // alu every cycle vs mul burst 5..9: bus alternates, per-source order kept
        step(0, 0, 0, 0, 1'b0, 1'b1); chk("reset3", 0, 4'b0000, 0);
        step(10, 0, 5, 0, 1'b0, 1'b0); chk("alt_0", 10, 4'b0000, 0);
        step(11, 0, 6, 0, 1'b0, 1'b0); chk("alt_1", 5, 4'b0000, 0);
        step(12, 0, 7, 0, 1'b0, 1'b0); chk("alt_2", 11, 4'b0000, 0);
        step(13, 0, 8, 0, 1'b0, 1'b0); chk("alt_3", 6, 4'b0000, 0);
        step(14, 0, 9, 0, 1'b0, 1'b0); chk("alt_4", 12, 4'b0000, 0);
        idle(); chk("alt_5", 7, 4'b0000, 0);
        idle(); chk("alt_6", 13, 4'b0000, 0);
        idle(); chk("alt_7", 8, 4'b0000, 0);
        idle(); chk("alt_8", 14, 4'b0000, 0);
        idle(); chk("alt_9", 9, 4'b0000, 0);
        idle(); chk("alt_10", 0, 4'b0000, 0);

        // div fills to 4, full pop+push keeps 4, then a no-pop input is dropped
        step(0, 0, 0, 0, 1'b0, 1'b1); chk("reset4", 0, 4'b0000, 0);
        step(1, 2, 3, 4, 1'b0, 1'b0); chk("div_c0", 1, 4'b0000, 0);
        step(0, 0, 0, 5, 1'b0, 1'b0); chk("div_c1", 2, 4'b0000, 0);
        step(0, 0, 0, 6, 1'b0, 1'b0); chk("div_c2", 3, 4'b0000, 0);
        step(0, 0, 0, 7, 1'b0, 1'b0); chk("div_c3", 4, 4'b0000, 0);
        step(8, 0, 0, 11, 1'b0, 1'b0); chk("div_full", 8, 4'b1000, 0);
        step(0, 0, 0, 12, 1'b0, 1'b0); chk("div_poppush", 5, 4'b1000, 0);
        step(13, 0, 0, 14, 1'b0, 1'b0); chk("div_drop", 13, 4'b1000, 1);
        idle(); chk("div_d0", 6, 4'b0000, 1);
        idle(); chk("div_d1", 7, 4'b0000, 1);
        idle(); chk("div_d2", 11, 4'b0000, 1);
        idle(); chk("div_d3", 12, 4'b0000, 1);
        idle(); chk("div_d4", 0, 4'b0000, 1);

        // flush with three buffered results: none ever broadcast, overflow kept, rr back to 0
        step(1, 2, 3, 4, 1'b0, 1'b0); chk("fl_load", 1, 4'b0000, 1);
        step(5, 0, 0, 0, 1'b1, 1'b0); chk("fl_c1", 0, 4'b0000, 1);
        idle(); chk("fl_c2", 0, 4'b0000, 1);
        idle(); chk("fl_c3", 0, 4'b0000, 1);
        step(7, 6, 0, 0, 1'b0, 1'b0); chk("fl_rr_a", 7, 4'b0000, 1);
        idle(); chk("fl_rr_b", 6, 4'b0000, 1);
        idle(); chk("fl_rr_c", 0, 4'b0000, 1);

        // mid-operation reset: buffered results discarded, overflow cleared
        step(1, 2, 3, 4, 1'b0, 1'b0); chk("rs_load", 3, 4'b0000, 1);
        step(0, 0, 0, 0, 1'b0, 1'b1); chk("rs_c1", 0, 4'b0000, 0);
        idle(); chk("rs_c2", 0, 4'b0000, 0);
        idle(); chk("rs_c3", 0, 4'b0000, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
